// File: rtl/geofence_driver.sv
// geofence_driver: buffers six-point sets, streams them into the geofence engine,
// and returns each result with a sequence tag; a watchdog flags lost results.
module geofence_driver #(
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic [10:0] in_r,
  output logic        fence_reset,
  output logic [9:0]  fence_x,
  output logic [9:0]  fence_y,
  output logic [10:0] fence_r,
  input  logic        fence_valid,
  input  logic        fence_inside,
  output logic        res_valid,
  output logic        res_inside,
  output logic [7:0]  res_tag,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state, state_n;
  logic [30:0] mem [12];
  logic [3:0] wr_ptr, rd_ptr, count, count_n;
  logic [2:0] k;
  logic [15:0] timer;
  logic push, pop, hit, expire;
  assign push = in_valid && in_ready;
  assign pop = state == SEND;
  assign hit = state == WAIT && fence_valid;
  // a result on the final WAIT cycle beats the timeout
  assign expire = state == WAIT && !fence_valid && timer == 16'(TIMEOUT - 1);
  assign count_n = count + {3'b0, push} - {3'b0, pop};
  assign fence_reset = state == IDLE;
  assign busy = state != IDLE;
  assign {fence_x, fence_y, fence_r} = pop ? mem[rd_ptr] : 31'd0;
  always_comb begin
    state_n = state;
    if (state == IDLE && count >= 4'd6) state_n = SEND;
    if (state == SEND && k == 3'd5) state_n = WAIT;
    if (hit || expire) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_x, in_y, in_r};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      k <= '0;
      timer <= '0;
      in_ready <= 1'b0;
      res_valid <= 1'b0;
      res_inside <= 1'b0;
      res_tag <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      in_ready <= count_n < 4'd12;
      if (push) wr_ptr <= wr_ptr == 4'd11 ? 4'd0 : wr_ptr + 4'd1;
      if (pop) rd_ptr <= rd_ptr == 4'd11 ? 4'd0 : rd_ptr + 4'd1;
      k <= pop ? k + 3'd1 : 3'd0;
      timer <= state == WAIT ? timer + 16'd1 : 16'd0;
      res_valid <= hit;
      if (hit) res_inside <= fence_inside;
      if (res_valid || expire) res_tag <= res_tag + 8'd1;
      err <= err | expire;
    end
  end
endmodule

// File: tb/tb_geofence_driver.sv
// tb_geofence_driver: directed scenarios with random point data, checked against a
// point scoreboard and a cycle-level engine model driven from the observed outputs.
module tb_geofence_driver;
  localparam int TO = 300;
  logic clk = 0, reset = 1, in_valid = 0, fence_valid = 0, fence_inside = 0;
  logic [9:0] in_x = 0, in_y = 0;
  logic [10:0] in_r = 0;
  logic in_ready, fence_reset, res_valid, res_inside, err, busy;
  logic [9:0] fence_x, fence_y;
  logic [10:0] fence_r;
  logic [7:0] res_tag;
  int tests = 0, fails = 0, cyc = 0;
  logic [30:0] q[$];
  int cfg_delay = -1;
  bit cfg_inside = 0, stray = 0;
  int sc = 0, wc = -1, wcyc = 0, fv_cyc = 0;
  bit pend = 0, fin = 0, exp_err = 0, exp_in = 0, fv = 0;
  logic [7:0] exp_tag = 0;
  logic [30:0] p;

  geofence_driver #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .fence_reset(fence_reset),
    .fence_x(fence_x), .fence_y(fence_y), .fence_r(fence_r),
    .fence_valid(fence_valid), .fence_inside(fence_inside),
    .res_valid(res_valid), .res_inside(res_inside), .res_tag(res_tag),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model and scoreboard: the first six cycles with fence_reset low must
  // present the next six pushed points; the engine answers cfg_delay cycles later.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      sc = 0; wc = -1; pend = 0; fin = 1; exp_err = 0; exp_tag = 0; fence_valid = 0;
    end else begin
      check("res_valid", 32'(res_valid), 32'(pend));
      if (pend) begin
        check("res_inside", 32'(res_inside), 32'(exp_in));
        check("res_tag", 32'(res_tag), 32'(exp_tag));
        exp_tag++;
      end
      check("err", 32'(err), 32'(exp_err));
      if (fin) check("fence_reset_back", 32'(fence_reset), 32'd1);
      pend = 0; fin = 0; fv = 0;
      if (!fence_reset) begin
        if (sc == 0) check("set_available", 32'(q.size() >= 6), 32'd1);
        if (sc < 6) begin
          p = q.size() > 0 ? q.pop_front() : '1;
          check("send_point", 32'({fence_x, fence_y, fence_r}), 32'(p));
          if (sc == 5) wc = cfg_delay;
        end else begin
          check("wait_zero", 32'({fence_x, fence_y, fence_r}), 32'd0);
          wcyc = sc - 5;
          fv = wc == wcyc;
          if (fv) begin
            pend = 1; exp_in = cfg_inside; fin = 1; fv_cyc = cyc;
          end else if (wcyc == TO) begin
            exp_err = 1; exp_tag++; fin = 1;
          end
        end
        sc++;
      end else begin
        check("idle_zero", 32'({fence_x, fence_y, fence_r}), 32'd0);
        sc = 0;
      end
      fence_valid = fv || stray;
      fence_inside = stray ? 1'b1 : cfg_inside;
    end
  end

  task automatic push_pts(input int n, input bit pat, output int last);
    bit acc;
    int g;
    logic [30:0] pi;
    last = 0;
    for (int i = 0; i < n; i++) begin
      pi = pat ? {10'(i * 10), 10'(i * 20), 11'(i + 1)} : 31'($urandom);
      {in_x, in_y, in_r} = pi;
      in_valid = 1;
      g = 0;
      do begin
        acc = in_ready;
        last = cyc;
        @(posedge clk); #1;
        g++;
      end while (!acc && g < 1000);
      if (acc) q.push_back(pi);
      else check("push_accept", 32'(acc), 32'd1);
    end
    in_valid = 0;
  endtask

  task automatic wait_rv(output int c);
    int g = 0;
    while (res_valid !== 1'b1 && g < 1000) begin @(posedge clk); #1; g++; end
    check("res_valid_arrives", 32'(g < 1000), 32'd1);
    c = cyc;
  endtask

  task automatic wait_send(output int c);
    int g = 0;
    while (fence_reset !== 1'b1 && g < 1000) begin @(posedge clk); #1; g++; end
    while (fence_reset !== 1'b0 && g < 2000) begin @(posedge clk); #1; g++; end
    check("send_arrives", 32'(g < 2000), 32'd1);
    c = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c, rv;
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_fence_reset", 32'(fence_reset), 32'd1);
    check("rst_fence_xyr", 32'({fence_x, fence_y, fence_r}), 32'd0);
    check("rst_res", 32'({res_valid, res_inside, res_tag}), 32'd0);
    check("rst_err_busy", 32'({err, busy}), 32'd0);
    reset = 0;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    // single set, inside
    cfg_delay = 200; cfg_inside = 1;
    push_pts(6, 1, t);
    wait_send(c);
    check("in_to_engine_latency", 32'(c), 32'(t + 2));
    repeat (7) @(posedge clk); #1;
    check("busy_in_wait", 32'(busy), 32'd1);
    wait_rv(rv);
    check("single_tag", 32'(res_tag), 32'd0);
    check("single_inside", 32'(res_inside), 32'd1);
    check("result_latency", 32'(rv), 32'(fv_cyc + 1));
    // back-to-back sets
    cfg_inside = 0;
    push_pts(12, 0, t);
    wait_rv(rv);
    check("b2b_first", 32'({res_tag, res_inside}), 32'({8'd1, 1'b0}));
    cfg_inside = 1;
    wait_send(c);
    check("buffer_latency", 32'(c), 32'(rv + 1));
    wait_rv(rv);
    check("b2b_second", 32'({res_tag, res_inside}), 32'({8'd2, 1'b1}));
    // stray strobe in IDLE
    @(posedge clk); #1;
    stray = 1;
    @(posedge clk); #1;
    stray = 0;
    repeat (3) @(posedge clk); #1;
    check("stray_busy", 32'(busy), 32'd0);
    check("tag_after_pulse", 32'(res_tag), 32'd3);
    // strobe on the final WAIT cycle
    cfg_delay = TO; cfg_inside = 0;
    push_pts(6, 0, t);
    wait_rv(rv);
    check("tie_tag", 32'(res_tag), 32'd3);
    @(posedge clk); #1;
    check("tie_no_err", 32'(err), 32'd0);
    // timeout
    cfg_delay = -1;
    push_pts(6, 0, t);
    wait_send(c);
    repeat (5 + TO) @(posedge clk); #1;
    check("timeout_not_yet", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_idle", 32'({fence_reset, busy}), 32'b10);
    cfg_delay = 40; cfg_inside = 1;
    push_pts(6, 0, t);
    wait_rv(rv);
    check("tag_after_timeout", 32'(res_tag), 32'd5);
    // FIFO full with a silent engine
    cfg_delay = -1;
    push_pts(18, 0, t);
    {in_x, in_y, in_r} = 31'($urandom);
    in_valid = 1;
    @(posedge clk); #1;
    check("full_not_ready", 32'(in_ready), 32'd0);
    repeat (8) @(posedge clk); #1;
    check("full_still_held", 32'(in_ready), 32'd0);
    in_valid = 0;
    // reset during SEND k=3 of the next set
    wait_send(c);
    repeat (3) @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("reset_fence_reset", 32'(fence_reset), 32'd1);
    check("reset_clears", 32'({busy, err, res_tag}), 32'd0);
    repeat (5) @(posedge clk); #1;
    check("reset_fifo_empty", 32'({fence_reset, in_ready}), 32'b11);
    cfg_delay = 30; cfg_inside = 0;
    push_pts(6, 0, t);
    wait_rv(rv);
    check("fresh_tag", 32'(res_tag), 32'd0);
    check("fresh_err", 32'(err), 32'd0);
    repeat (3) @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/geofence_driver.md
# geofence_driver

Host-side source and sink for the geofence engine. It buffers up to two six-point test sets from an upstream valid/ready stream and holds the engine in reset while no complete set is available. It streams each set on the engine's fixed six-cycle X/Y/R input window, then waits for the engine's one-cycle `valid` and returns the result with a sequence tag. A watchdog flags any set whose result never arrives.

## Interface
- `TIMEOUT`, 4095: max cycles in WAIT before error; legal range 1..65535.
- `clk`  in  1  clock; sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream point valid.
- `in_ready`  out  1  buffer can accept a point.
- `in_x`  in  10  point X.
- `in_y`  in  10  point Y.
- `in_r`  in  11  point distance R.
- `fence_reset`  out  1  reset to the geofence engine, active-high.
- `fence_x`  out  10  engine X input.
- `fence_y`  out  10  engine Y input.
- `fence_r`  out  11  engine R input.
- `fence_valid`  in  1  engine result strobe.
- `fence_inside`  in  1  engine result, qualified by `fence_valid`.
- `res_valid`  out  1  one-cycle result pulse; no backpressure.
- `res_inside`  out  1  captured result.
- `res_tag`  out  8  set sequence number, wraps 255→0.
- `err`  out  1  sticky timeout flag, cleared only by `reset`.
- `busy`  out  1  high in SEND and WAIT.

## Operation
- **Buffer:** 12-entry FIFO of {x,y,r}, 31 bits per entry.
  - `in_ready` = count < 12.
  - A push happens on `in_valid && in_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - Points are consumed strictly in arrival order; points 0..5 of each set are the next six FIFO entries.
- **FSM, IDLE:**
  - `fence_reset`=1; `fence_x/y/r`=0.
  - When count ≥ 6, go to SEND with k=0.
- **FSM, SEND (6 cycles, k=0..5):**
  - `fence_reset`=0; `fence_x/y/r` = FIFO head; pop every cycle.
  - After k=5, go to WAIT with the timer cleared.
- **FSM, WAIT:**
  - `fence_reset`=0; `fence_x/y/r`=0; timer increments each cycle.
  - On `fence_valid`=1:
    - capture `fence_inside`;
    - next cycle `res_valid`=1 with `res_inside` and `res_tag`;
    - `res_tag` increments after the pulse;
    - go to IDLE.
  - On timer reaching `TIMEOUT` without `fence_valid`:
    - set `err`=1;
    - go to IDLE with no `res_valid`;
    - `res_tag` still increments, so the set's number is consumed.
- **`fence_valid` outside WAIT:** ignored.
- **`fence_valid` and timeout on the same cycle:** the result wins and `err` is not set.
- **Reset mid-operation:**
  - FIFO is emptied; FSM returns to IDLE.
  - `fence_reset`=1 from the cycle after reset is sampled.
  - The partial set is discarded; `res_tag` and `err` are cleared.
- **Reset values (all outputs, registered):**
  - `fence_reset`=1
  - `fence_x/y/r`=0
  - `in_ready`=0 while reset is high, 1 after
  - `res_valid`=0, `res_inside`=0, `res_tag`=0
  - `err`=0, `busy`=0

## Timing
- **Set start:** `fence_reset` falls in the same cycle that point 0 is driven.
  - The engine samples point k at the end of SEND cycle k, so no bubble is allowed between points.
- **IDLE length:** at least one cycle between consecutive sets.
  - `fence_reset` is asserted in the cycle after the result is captured, and the engine is re-initialised before every set.
- **Buffer latency:** with the FIFO already holding ≥6 points, SEND begins two cycles after `fence_valid`.
  - Cycle 1: capture the result and enter IDLE.
  - Cycle 2: SEND k=0.
- **Input-to-engine latency:** the 6th point pushed at cycle t with the FSM in IDLE gives SEND k=0 at t+2.
- **Result latency:** `res_valid` follows `fence_valid` by exactly one cycle.
- **Timeout:** `err` rises `TIMEOUT`+1 cycles after the last SEND cycle.

## Test plan
- **Single set, inside:**
  - Stimulus: push 6 points (x=k·10, y=k·20, r=k+1); bench model returns `fence_valid`=1, `fence_inside`=1 200 cycles after the last sample.
  - Required: `fence_reset` low for exactly the 6 SEND cycles plus WAIT; `fence_x` sequence 0,10,…,50; `res_valid` one cycle after `fence_valid` with `res_inside`=1, `res_tag`=0.
- **Back-to-back sets:**
  - Stimulus: push 12 points up front; model answers inside=0, then inside=1.
  - Required: a single `fence_reset` high cycle between sets; results (tag0, 0) then (tag1, 1); the second SEND starts 2 cycles after the first `fence_valid`.
- **FIFO full:**
  - Stimulus: `TIMEOUT`=4095 and a silent model; push 18 points continuously.
  - Required: 6 points drain into SEND; `in_ready` falls after count reaches 12; the 19th `in_valid` is held and not accepted.
- **Timeout:**
  - Stimulus: `TIMEOUT`=16; the model never asserts `fence_valid`.
  - Required: `err`=1 17 cycles after SEND k=5; no `res_valid`; FSM back in IDLE; the next set gets `res_tag`=1.
- **Reset mid-SEND:**
  - Stimulus: assert `reset` during SEND k=3, then push a fresh set.
  - Required: `fence_reset`=1 the cycle after reset is sampled; FIFO count=0; the fresh set streams from point 0 with `res_tag`=0, `err`=0.
- **Stray strobe and tie:**
  - Stimulus: `fence_valid` pulsed in IDLE; then `fence_valid` coincident with timer=`TIMEOUT`.
  - Required: the IDLE strobe is ignored; the coincident strobe produces `res_valid` and leaves `err`=0.
